// File: rtl/main_memory_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// main_memory_responder: fixed-latency word-addressed memory slave.
// Rev 1.0
// ---------------------------------------------------------------------------
module main_memory_responder #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 8,
  parameter int                    LATENCY    = 3,
  parameter logic [DATA_WIDTH-1:0] FILL_VALUE = 32'hDEADBEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_ready,
  output logic                  busy,
  output logic                  proto_err,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  op_write;
  logic [DEPTH_LOG2-1:0] op_idx;
  logic [DATA_WIDTH-1:0] op_data;
  logic [DEPTH-1:0]      valid;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] req_idx;
  logic                  exec_write;
  logic                  unused_addr_bits;

  // Only the word index selects storage; byte offset and upper bits alias.
  assign req_idx          = mem_addr[DEPTH_LOG2+1:2];
  assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2], mem_addr[1:0]};
  assign exec_write       = (state == S_BUSY) && (cnt == '0) && op_write;

  // Storage is deliberately not reset; a reset at the execute edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && exec_write) begin
      mem[op_idx] <= op_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      op_write      <= 1'b0;
      op_idx        <= '0;
      op_data       <= '0;
      valid         <= '0;
      mem_read_data <= '0;
      mem_ready     <= 1'b0;
      busy          <= 1'b0;
      proto_err     <= 1'b0;
      rd_count      <= 16'd0;
      wr_count      <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mem_read || mem_write) begin
            op_idx   <= req_idx;
            op_data  <= mem_write_data;
            op_write <= mem_write;
            cnt      <= CW'(LATENCY - 1);
            busy     <= 1'b1;
            state    <= S_BUSY;
            if (mem_read && mem_write) begin
              proto_err <= 1'b1;
            end
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            mem_ready <= 1'b1;
            if (op_write) begin
              valid[op_idx] <= 1'b1;
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
              mem_read_data <= valid[op_idx] ? mem[op_idx] : FILL_VALUE;
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          if (!mem_read && !mem_write) begin
            state     <= S_IDLE;
            mem_ready <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// Randomized bench with a transaction-level reference model of the responder.
module tb_main_memory_responder;

  localparam int          LAT  = 3;
  localparam int          DL   = 8;
  localparam logic [31:0] FILL = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_write_data = 32'h0;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        busy;
  logic        proto_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  main_memory_responder #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_LOG2(DL), .LATENCY(LAT), .FILL_VALUE(FILL)
  ) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready), .busy(busy),
    .proto_err(proto_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  // Edge counter and reset as sampled at the latest rising edge.
  int cyc   = 0;
  bit rst_s = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  // Current transaction, written only by the driver.
  int          t_acc  = 0;
  int          t_rel  = 0;
  bit          t_wr   = 1'b0;
  bit          t_both = 1'b0;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_data = 32'h0;

  // Hand-computed expectations, written only by the driver.
  int          pin_cyc [64];
  logic [31:0] pin_rd  [64];
  logic [15:0] pin_rc  [64];
  logic [15:0] pin_wc  [64];
  bit          pin_pe  [64];
  int          pin_n = 0;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: storage of written words, counters and flags.
  logic [31:0] mem_m [int];
  logic [31:0] m_rd = 32'h0;
  logic [15:0] m_rc = 16'h0;
  logic [15:0] m_wc = 16'h0;
  bit          m_pe = 1'b0;
  int          pin_k = 0;

  always @(negedge clk) begin
    int  idx;
    bit  e_busy;
    bit  e_ready;
    if (rst_s) begin
      mem_m.delete();
      m_rd = 32'h0; m_rc = 16'h0; m_wc = 16'h0; m_pe = 1'b0;
    end else if (cyc >= t_acc && cyc < t_rel) begin
      if (cyc == t_acc && t_both) m_pe = 1'b1;
      if (cyc == t_acc + LAT) begin
        idx = int'(t_addr[DL+1:2]);
        if (t_wr) begin
          mem_m[idx] = t_data;
          if (m_wc != 16'hFFFF) m_wc = m_wc + 16'd1;
        end else begin
          m_rd = mem_m.exists(idx) ? mem_m[idx] : FILL;
          if (m_rc != 16'hFFFF) m_rc = m_rc + 16'd1;
        end
      end
    end
    e_busy  = !rst_s && cyc >= t_acc && cyc < t_acc + LAT && cyc < t_rel;
    e_ready = !rst_s && cyc >= t_acc + LAT && cyc < t_rel;
    chk("busy",      32'(busy),      32'(e_busy));
    chk("mem_ready", 32'(mem_ready), 32'(e_ready));
    chk("rdata",     mem_read_data,  m_rd);
    chk("rd_count",  32'(rd_count),  32'(m_rc));
    chk("wr_count",  32'(wr_count),  32'(m_wc));
    chk("proto_err", 32'(proto_err), 32'(m_pe));
    while (pin_k < pin_n && pin_cyc[pin_k] == cyc) begin
      chk("pin_rdata",    mem_read_data,   pin_rd[pin_k]);
      chk("pin_rd_count", 32'(rd_count),   32'(pin_rc[pin_k]));
      chk("pin_wr_count", 32'(wr_count),   32'(pin_wc[pin_k]));
      chk("pin_proto",    32'(proto_err),  32'(pin_pe[pin_k]));
      chk("pin_model",    m_rd,            pin_rd[pin_k]);
      pin_k++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // d: first edge (relative to acceptance) that sees the request low.
  // roff >= 0: reset is sampled at acceptance+roff+1 instead of completing.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input int d, input int roff,
                     input bit pin, input logic [31:0] prd, input logic [15:0] prc,
                     input logic [15:0] pwc, input bit ppe);
    int a;
    while (cyc < t_rel) step();
    a      = cyc + 1;
    t_acc  = a;
    t_wr   = wr;
    t_both = rd && wr;
    t_addr = addr;
    t_data = data;
    if (roff >= 0) t_rel = a + roff + 1;
    else           t_rel = (d > LAT + 1) ? a + d : a + LAT + 1;
    if (pin) begin
      pin_cyc[pin_n] = (roff >= 0) ? t_rel : a + LAT;
      pin_rd[pin_n]  = prd;
      pin_rc[pin_n]  = prc;
      pin_wc[pin_n]  = pwc;
      pin_pe[pin_n]  = ppe;
      pin_n++;
    end
    mem_read       = rd;
    mem_write      = wr;
    mem_addr       = addr;
    mem_write_data = data;
    do begin
      step();
      if (cyc < a + LAT) begin
        mem_addr       = $urandom;
        mem_write_data = $urandom;
      end
      if (cyc == a + d - 1) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      if (roff >= 0 && cyc == a + roff) begin
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end while (cyc < t_rel);
    reset = 1'b0;
  endtask

  task automatic pulse_reset();
    while (cyc < t_rel) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] addr;
    int          r;
    int          d;
    int          roff;
    bit          rd;
    bit          wr;
    repeat (3) step();
    reset = 1'b0;
    step();

    txn(1, 0, 32'h1000, 32'h0, LAT + 1, -1, 1, FILL, 16'd1, 16'd0, 0);
    pulse_reset();
    txn(0, 1, 32'h40,  32'h12345678, LAT + 1, -1, 1, 32'h0,        16'd0, 16'd1, 0);
    txn(1, 0, 32'h40,  32'h0,        LAT + 2, -1, 1, 32'h12345678, 16'd1, 16'd1, 0);
    txn(0, 1, 32'h40,  32'hAAAA5555, LAT + 1, -1, 1, 32'h12345678, 16'd1, 16'd2, 0);
    txn(1, 0, 32'h440, 32'h0,        LAT + 1, -1, 1, 32'hAAAA5555, 16'd2, 16'd2, 0);
    txn(1, 0, 32'h44,  32'h0,        LAT + 1, -1, 1, FILL,         16'd3, 16'd2, 0);
    txn(1, 1, 32'h80,  32'hCAFEF00D, LAT + 1, -1, 1, FILL,         16'd3, 16'd3, 1);
    txn(1, 0, 32'h80,  32'h0,        LAT + 1, -1, 1, 32'hCAFEF00D, 16'd4, 16'd3, 1);
    txn(0, 1, 32'h100, 32'h11111111, LAT + 1,  1, 1, 32'h0,        16'd0, 16'd0, 0);
    txn(1, 0, 32'h100, 32'h0,        LAT + 1, -1, 1, FILL,         16'd1, 16'd0, 0);
    txn(0, 1, 32'h200, 32'h5A5A0001, LAT + 1, -1, 1, FILL,         16'd1, 16'd1, 0);
    txn(1, 0, 32'h200, 32'h0,        1,       -1, 1, 32'h5A5A0001, 16'd2, 16'd1, 0);
    // Reset landing exactly on the execute edge must still drop the write.
    txn(0, 1, 32'h300, 32'h0BAD0BAD, LAT + 1, LAT - 1, 1, 32'h0,   16'd0, 16'd0, 0);
    txn(1, 0, 32'h300, 32'h0,        LAT + 1, -1, 1, FILL,         16'd1, 16'd0, 0);

    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) step();
      r    = int'($urandom_range(0, 99));
      rd   = (r < 45) || (r >= 95);
      wr   = (r >= 45);
      addr = ($urandom & 32'hFFFFFC00) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0) d = int'($urandom_range(1, LAT));
      else                           d = int'($urandom_range(LAT + 1, LAT + 4));
      roff = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, LAT - 1)) : -1;
      txn(rd, wr, addr, $urandom, d, roff, 0, 32'h0, 16'd0, 16'd0, 0);
    end

    while (cyc < t_rel) step();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
Behavioural-synthesisable main-memory slave that sits at the far end of the cache controller's memory port. It answers mem_read/mem_write requests with a fixed, parameterised latency, holds a word-addressed backing array, and raises mem_ready when each access completes. The block is used in cache benches and at SoC level as the backing store behind the cache.

Parameters:
DATA_WIDTH, 32, data word width in bits
ADDR_WIDTH, 32, byte-address width
DEPTH_LOG2, 8, log2 of the number of words in the array (256 words)
LATENCY, 3, cycles spent in BUSY per access; must be >= 1
FILL_VALUE, 32'hDEADBEEF, data returned when reading a word never written since reset

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  read request; level, held by the requester until mem_ready
mem_write  input  1  write request; level, held by the requester until mem_ready
mem_addr  input  ADDR_WIDTH  byte address; word index = mem_addr[DEPTH_LOG2+1:2]
mem_write_data  input  DATA_WIDTH  write data
mem_read_data  output  DATA_WIDTH  registered read data
mem_ready  output  1  access complete
busy  output  1  high in BUSY
proto_err  output  1  sticky flag: mem_read and mem_write were sampled high together
rd_count  output  16  completed reads, saturating
wr_count  output  16  completed writes, saturating

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; mem_read_data=0; mem_ready=0; busy=0; proto_err=0; rd_count=0; wr_count=0.
  - All per-word valid bits cleared.
  - Array data contents are not cleared.
  - Reset has priority over every other event, including mid-access. An in-flight write is dropped and the array is unchanged.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read or mem_write is high at a rising edge, the request is accepted: mem_addr and mem_write_data are latched, op type is latched, down-counter is loaded with LATENCY-1, and state goes to BUSY.
  - If both are high, the op is treated as a write and proto_err is set to 1 (sticky until reset).
- BUSY:
  - busy=1. The counter decrements each cycle.
  - At the edge where the counter is 0, the op executes and state goes to DONE.
  - Inputs other than reset are ignored in BUSY. Later changes to mem_addr or mem_write_data do not affect the latched op.
- Op execution:
  - Write: the latched data goes to array[index], valid[index] is set, and wr_count increments (saturates at 16'hFFFF).
  - Read: mem_read_data takes array[index] if valid[index] is set, otherwise FILL_VALUE. rd_count increments (saturating).
  - mem_read_data holds its value until the next completed read; writes do not change it.
- DONE:
  - mem_ready=1.
  - Goes to IDLE at the first edge where mem_read and mem_write are both low.
  - mem_ready stays high while the requester still holds a request.
  - If the request was dropped during BUSY, mem_ready is high for exactly one cycle.
- Timing: a request sampled at edge N produces mem_ready high after edge N+LATENCY. The earliest next acceptance is edge N+LATENCY+2 (one DONE cycle with the request low, one IDLE cycle).
- Address wrap: upper address bits above DEPTH_LOG2+1 and bits [1:0] are ignored. For example, 0x40 and 0x440 alias to the same word with default DEPTH_LOG2=8.
- All outputs are registered; no combinational path from input to output.

Test Plan:
1. Reset, then read 0x1000 held with LATENCY=3 -> mem_ready rises 3 edges after acceptance; mem_read_data=DEADBEEF; rd_count=1.
2. Write 0x40 data 12345678, drop on ready; then read 0x40 -> read returns 12345678; wr_count=1; rd_count=1.
3. Write 0x40=AAAA5555, then read 0x440 (alias) -> returns AAAA5555. Read 0x44 -> returns DEADBEEF.
4. Assert mem_read and mem_write together at 0x80, data CAFEF00D -> proto_err=1 and stays 1. A read of 0x80 then returns CAFEF00D.
5. Start write 0x100=11111111 and assert reset during BUSY -> all outputs return to reset values. A read of 0x100 returns DEADBEEF.
6. Read request pulsed for one cycle, then mem_addr changed during BUSY -> the original address is read, mem_ready is high for exactly 1 cycle, and the FSM returns to IDLE.
